// File: rtl/iob_timer_alarm_if.sv
// Signal bundle between the timer register file (master) and the compare/alarm stage (slave).
// Carries the timer value, the compare programming, the control pulses and the alarm status.
interface iob_timer_alarm_if #(
  parameter int DATA_W = 32,
  parameter int MISS_W = 8
);
  logic                  cke_i;
  logic [2*DATA_W-1:0]   timer_value_i;
  logic [DATA_W-1:0]     cmp_lo_i;
  logic [DATA_W-1:0]     cmp_hi_i;
  logic [DATA_W-1:0]     period_i;
  logic                  periodic_i;
  logic                  arm_i;
  logic                  disarm_i;
  logic                  ack_i;
  logic                  irq_o;
  logic                  armed_o;
  logic [MISS_W-1:0]     missed_o;
  logic [2*DATA_W-1:0]   cmp_o;

  modport master (
    output cke_i, timer_value_i, cmp_lo_i, cmp_hi_i, period_i,
           periodic_i, arm_i, disarm_i, ack_i,
    input  irq_o, armed_o, missed_o, cmp_o
  );

  modport slave (
    input  cke_i, timer_value_i, cmp_lo_i, cmp_hi_i, period_i,
           periodic_i, arm_i, disarm_i, ack_i,
    output irq_o, armed_o, missed_o, cmp_o
  );
endinterface

// File: rtl/iob_timer_alarm.sv
// Compare/alarm stage: raises a sticky irq when the free-running timer reaches the
// programmed compare value, with one-shot or auto-reload operation and a missed-alarm count.
module iob_timer_alarm #(
  parameter int DATA_W = 32,
  parameter int MISS_W = 8
) (
  input logic             clk_i,
  input logic             arst_n_i,
  iob_timer_alarm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  state_t                state_reg, state_next;
  logic [2*DATA_W-1:0]   cmp_reg, cmp_next;
  logic [DATA_W-1:0]     period_reg, period_next;
  logic                  mode_reg, mode_next;
  logic                  irq_reg, irq_next;
  logic [MISS_W-1:0]     missed_reg, missed_next;
  logic                  armed_reg, armed_next;
  logic                  match;
  logic                  match_taken;

  assign match       = (state_reg == ARMED) && (bus.timer_value_i >= cmp_reg);
  // A match only counts when no higher-priority control pulse claims the cycle.
  assign match_taken = bus.cke_i && !bus.disarm_i && !bus.arm_i && match;

  always_comb begin
    state_next  = state_reg;
    cmp_next    = cmp_reg;
    period_next = period_reg;
    mode_next   = mode_reg;
    irq_next    = irq_reg;
    missed_next = missed_reg;

    if (bus.cke_i) begin
      if (bus.disarm_i) begin
        state_next = IDLE;
      end else if (bus.arm_i) begin
        cmp_next    = {bus.cmp_hi_i, bus.cmp_lo_i};
        period_next = bus.period_i;
        mode_next   = bus.periodic_i;
        missed_next = '0;
        state_next  = ARMED;
      end else if (match) begin
        if (mode_reg && (period_reg != '0)) begin
          cmp_next = cmp_reg + {{DATA_W{1'b0}}, period_reg};
        end else begin
          state_next = DONE;
        end
      end

      // Match beats ack; an alarm landing on a still-pending irq is counted as missed
      // unless software acknowledged it in the same cycle.
      if (match_taken) begin
        irq_next = 1'b1;
        if (irq_reg && !bus.ack_i && (missed_reg != MISS_MAX)) begin
          missed_next = missed_reg + 1'b1;
        end
      end else if (bus.ack_i) begin
        irq_next = 1'b0;
      end
    end
  end

  assign armed_next = (state_next == ARMED);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg  <= IDLE;
      cmp_reg    <= '0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
      irq_reg    <= 1'b0;
      missed_reg <= '0;
      armed_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cmp_reg    <= cmp_next;
      period_reg <= period_next;
      mode_reg   <= mode_next;
      irq_reg    <= irq_next;
      missed_reg <= missed_next;
      armed_reg  <= armed_next;
    end
  end

  assign bus.irq_o    = irq_reg;
  assign bus.armed_o  = armed_reg;
  assign bus.missed_o = missed_reg;
  assign bus.cmp_o    = cmp_reg;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Directed bench for iob_timer_alarm; a second instance with a 2-bit missed counter
// shadows the same stimulus to exercise saturation.
module tb_iob_timer_alarm;

  logic clk;
  logic rst_n;

  int vectors_applied = 0;
  int miscompares     = 0;
  int hits;
  longint hit_sum;

  iob_timer_alarm_if #(.DATA_W(32), .MISS_W(8)) bus ();
  iob_timer_alarm_if #(.DATA_W(32), .MISS_W(2)) bus2 ();

  iob_timer_alarm #(.DATA_W(32), .MISS_W(8)) dut (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .bus      (bus.slave)
  );

  iob_timer_alarm #(.DATA_W(32), .MISS_W(2)) dut_sat (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .bus      (bus2.slave)
  );

  assign bus2.cke_i         = bus.cke_i;
  assign bus2.timer_value_i = bus.timer_value_i;
  assign bus2.cmp_lo_i      = bus.cmp_lo_i;
  assign bus2.cmp_hi_i      = bus.cmp_hi_i;
  assign bus2.period_i      = bus.period_i;
  assign bus2.periodic_i    = bus.periodic_i;
  assign bus2.arm_i         = bus.arm_i;
  assign bus2.disarm_i      = bus.disarm_i;
  assign bus2.ack_i         = bus.ack_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [31:0] lo, input logic [31:0] hi,
                     input logic [31:0] per, input logic periodic);
    bus.cmp_lo_i   = lo;
    bus.cmp_hi_i   = hi;
    bus.period_i   = per;
    bus.periodic_i = periodic;
    bus.arm_i      = 1'b1;
    step();
    bus.arm_i      = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.cke_i          = 1'b1;
    bus.timer_value_i  = '0;
    bus.cmp_lo_i       = '0;
    bus.cmp_hi_i       = '0;
    bus.period_i       = '0;
    bus.periodic_i     = 1'b0;
    bus.arm_i          = 1'b0;
    bus.disarm_i       = 1'b0;
    bus.ack_i          = 1'b0;

    // Reset state
    step();
    step();
    check("rst_irq",    64'(bus.irq_o),    64'd0);
    check("rst_armed",  64'(bus.armed_o),  64'd0);
    check("rst_missed", 64'(bus.missed_o), 64'd0);
    check("rst_cmp",    bus.cmp_o,         64'd0);
    #2 rst_n = 1'b1;
    $display("txn reset: irq=%0d armed=%0d cmp=0x%0h", bus.irq_o, bus.armed_o, bus.cmp_o);

    // One-shot at 0x10 with a ramping timer
    bus.timer_value_i = 64'd0;
    arm(32'h10, 32'h0, 32'd0, 1'b0);
    check("os_armed", 64'(bus.armed_o), 64'd1);
    check("os_cmp",   bus.cmp_o,        64'h10);
    for (int t = 1; t <= 20; t++) begin
      bus.timer_value_i = 64'(t);
      step();
      check("os_irq_ramp",   64'(bus.irq_o),   (t >= 16) ? 64'd1 : 64'd0);
      check("os_armed_ramp", 64'(bus.armed_o), (t >= 16) ? 64'd0 : 64'd1);
    end
    step();
    check("os_irq_sticky", 64'(bus.irq_o), 64'd1);
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    check("os_irq_ack", 64'(bus.irq_o), 64'd0);
    $display("txn one-shot: cmp=0x%0h irq=%0d armed=%0d", bus.cmp_o, bus.irq_o, bus.armed_o);

    // Periodic cmp=100 period=50, ack every irq
    bus.timer_value_i = 64'd0;
    arm(32'd100, 32'd0, 32'd50, 1'b1);
    hits    = 0;
    hit_sum = 0;
    for (int t = 0; t <= 260; t++) begin
      bus.timer_value_i = 64'(t);
      bus.ack_i         = bus.irq_o;
      step();
      if (bus.irq_o) begin
        hits++;
        hit_sum += longint'(t);
      end
    end
    bus.ack_i = 1'b0;
    check("per_hits",   64'(hits),          64'd4);
    check("per_hitsum", 64'(hit_sum),       64'd700);
    check("per_cmp",    bus.cmp_o,          64'd300);
    check("per_missed", 64'(bus.missed_o),  64'd0);
    check("per_armed",  64'(bus.armed_o),   64'd1);
    $display("txn periodic-ack: hits=%0d cmp=%0d", hits, bus.cmp_o);

    // Periodic cmp=10 period=5, never acked
    bus.timer_value_i = 64'd0;
    arm(32'd10, 32'd0, 32'd5, 1'b1);
    for (int t = 0; t <= 40; t++) begin
      bus.timer_value_i = 64'(t);
      step();
    end
    check("miss_irq",     64'(bus.irq_o),     64'd1);
    check("miss_count",   64'(bus.missed_o),  64'd6);
    check("miss_sat",     64'(bus2.missed_o), 64'd3);
    check("miss_cmp",     bus.cmp_o,          64'd45);
    $display("txn periodic-miss: missed=%0d missed_sat=%0d cmp=%0d",
             bus.missed_o, bus2.missed_o, bus.cmp_o);

    // Ack and match in the same cycle
    bus.timer_value_i = 64'd45;
    bus.ack_i         = 1'b1;
    step();
    check("ackmatch_irq",    64'(bus.irq_o),    64'd1);
    check("ackmatch_missed", 64'(bus.missed_o), 64'd6);
    check("ackmatch_cmp",    bus.cmp_o,         64'd50);
    bus.timer_value_i = 64'd46;
    step();
    bus.ack_i = 1'b0;
    check("ack_clear", 64'(bus.irq_o), 64'd0);

    // Arm and disarm together: disarm wins
    bus.cmp_lo_i = 32'd999;
    bus.arm_i    = 1'b1;
    bus.disarm_i = 1'b1;
    step();
    bus.arm_i    = 1'b0;
    bus.disarm_i = 1'b0;
    check("armdis_armed",  64'(bus.armed_o),  64'd0);
    check("armdis_cmp",    bus.cmp_o,         64'd50);
    check("armdis_missed", 64'(bus.missed_o), 64'd6);
    $display("txn same-cycle: armed=%0d cmp=%0d", bus.armed_o, bus.cmp_o);

    // Compare value already in the past
    bus.timer_value_i = 64'd1000;
    arm(32'd5, 32'd0, 32'd0, 1'b0);
    check("past_armed0", 64'(bus.armed_o), 64'd1);
    check("past_irq0",   64'(bus.irq_o),   64'd0);
    step();
    check("past_irq1",   64'(bus.irq_o),   64'd1);
    check("past_armed1", 64'(bus.armed_o), 64'd0);
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    check("past_ack", 64'(bus.irq_o), 64'd0);

    // Periodic with zero period behaves as one-shot
    arm(32'd2000, 32'd0, 32'd0, 1'b1);
    check("p0_armed0", 64'(bus.armed_o), 64'd1);
    bus.timer_value_i = 64'd2000;
    step();
    check("p0_irq",   64'(bus.irq_o),   64'd1);
    check("p0_armed", 64'(bus.armed_o), 64'd0);
    check("p0_cmp",   bus.cmp_o,        64'd2000);
    bus.timer_value_i = 64'd3000;
    bus.ack_i         = 1'b1;
    step();
    bus.ack_i = 1'b0;
    check("p0_done_irq",   64'(bus.irq_o),   64'd0);
    check("p0_done_armed", 64'(bus.armed_o), 64'd0);
    $display("txn past/zero-period: cmp=%0d armed=%0d", bus.cmp_o, bus.armed_o);

    // Asynchronous reset with irq pending
    arm(32'd3100, 32'd0, 32'd10, 1'b1);
    bus.timer_value_i = 64'd3100;
    step();
    check("pre_rst_irq", 64'(bus.irq_o), 64'd1);
    check("pre_rst_cmp", bus.cmp_o,      64'd3110);
    #2 rst_n = 1'b0;
    #1;
    check("arst_irq",    64'(bus.irq_o),    64'd0);
    check("arst_armed",  64'(bus.armed_o),  64'd0);
    check("arst_missed", 64'(bus.missed_o), 64'd0);
    check("arst_cmp",    bus.cmp_o,         64'd0);
    #3 rst_n = 1'b1;
    bus.timer_value_i = 64'd5000;
    step();
    step();
    check("post_rst_irq",   64'(bus.irq_o),   64'd0);
    check("post_rst_armed", 64'(bus.armed_o), 64'd0);
    $display("txn async-reset: irq=%0d armed=%0d", bus.irq_o, bus.armed_o);

    // Clock enable low across a match
    arm(32'd6000, 32'd0, 32'd0, 1'b0);
    bus.cke_i         = 1'b0;
    bus.timer_value_i = 64'd6000;
    bus.disarm_i      = 1'b1;
    step();
    check("cke_irq",   64'(bus.irq_o),   64'd0);
    check("cke_armed", 64'(bus.armed_o), 64'd1);
    bus.disarm_i = 1'b0;
    bus.cke_i    = 1'b1;
    step();
    check("cke_on_irq",   64'(bus.irq_o),   64'd1);
    check("cke_on_armed", 64'(bus.armed_o), 64'd0);
    $display("txn cke-hold: irq=%0d armed=%0d", bus.irq_o, bus.armed_o);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_timer_alarm.md
# iob_timer_alarm

Compare/alarm stage downstream of the 64-bit timer counter. It consumes the free-running timer value and raises an interrupt when that value reaches a programmed 64-bit compare value. It supports one-shot and periodic (auto-reload) modes, plus a saturating count of alarms missed while an interrupt is still pending. The block sits beside the timer's software register file, and its irq output feeds the system interrupt controller.

## Interface
- DATA_W, 32: CSR word width; the timer value and compare value are 2*DATA_W bits wide.
- MISS_W, 8: width of the missed-alarm counter.

- clk_i  in  1  system clock
- arst_n_i  in  1  reset, asynchronous, active-low
- cke_i  in  1  clock enable; when 0, all state holds and input pulses are ignored
- timer_value_i  in  2*DATA_W  current timer count, unsigned
- cmp_lo_i  in  DATA_W  compare value, low word
- cmp_hi_i  in  DATA_W  compare value, high word
- period_i  in  DATA_W  reload increment for periodic mode, zero-extended to 2*DATA_W
- periodic_i  in  1  mode select, sampled only when arm_i is accepted
- arm_i  in  1  one-cycle pulse: load compare value and arm
- disarm_i  in  1  one-cycle pulse: return to IDLE
- ack_i  in  1  one-cycle pulse: clear irq_o
- irq_o  out  1  registered alarm interrupt, level, sticky until ack
- armed_o  out  1  high in state ARMED
- missed_o  out  MISS_W  saturating count of alarms lost while irq_o was high
- cmp_o  out  2*DATA_W  current compare register

## Operation
- States: IDLE, ARMED, DONE.
- Registers: cmp (2*DATA_W), period (DATA_W), mode (1), irq (1), missed (MISS_W), state.
- Match condition: state==ARMED and timer_value_i >= cmp, using an unsigned 2*DATA_W compare. Using >= means a compare value already in the past fires on the first armed cycle.
- Priority per enabled cycle: disarm_i > arm_i > match.
  - disarm_i: state goes to IDLE. cmp, irq and missed are unchanged.
  - arm_i: cmp <= {cmp_hi_i,cmp_lo_i}, period <= period_i, mode <= periodic_i, missed <= 0, state goes to ARMED. irq is unchanged. This applies from any state, including re-arming while ARMED.
  - Match in one-shot mode, or in periodic mode with period==0: state goes to DONE. cmp is held.
  - Match in periodic mode with period!=0: cmp <= cmp + period, modulo 2^(2*DATA_W). State stays ARMED.
- Every match sets irq. If irq was already 1 at that edge, missed increments, saturating at 2^MISS_W-1.
- ack_i clears irq. If ack_i and a match occur in the same cycle, the match wins: irq stays 1 and missed does not increment.
- Wrap-around: a reloaded cmp that wraps past 2^(2*DATA_W) compares as a small value, so it matches on the next cycle. This is accepted behaviour; software guarantees that cmp + period does not wrap.
- DONE and IDLE ignore the timer and exit only via arm_i.

## Timing
- Reset values, asynchronous on arst_n_i low: state=IDLE, cmp=0, period=0, mode=0, irq_o=0, armed_o=0, missed_o=0, cmp_o=0.
- All outputs are registered.
- Alarm latency:
  - timer_value_i >= cmp sampled at edge N gives irq_o=1 after edge N.
  - In one-shot mode, armed_o falls at the same edge.
- Arm latency: arm_i at edge N gives armed_o=1 and the new cmp_o after edge N. The first possible match is evaluated at edge N+1.
- ack_i at edge N gives irq_o=0 after edge N, unless a match occurs at edge N.
- cke_i=0: no register updates; pulses in that cycle are lost.
- Reset asserted mid-operation: immediate return to reset values. No alarm fires after release until a new arm_i.

## Test plan
- Reset, then arm with cmp=0x0000_0000_0000_0010, one-shot; ramp the timer from 0 by 1 per cycle -> irq_o rises the cycle after timer=0x10, armed_o=0, state DONE, and irq_o stays high until ack_i.
- Periodic, cmp=100, period=50; ramp the timer to 260 and ack each irq -> irqs at timers 100, 150, 200 and 250; cmp_o=300 at the end.
- Periodic, cmp=10, period=5, no ack, timer to 40 -> irq_o=1 and missed_o=6 (fires at 15..40). Repeat with MISS_W=2 -> missed_o saturates at 3.
- Same-cycle ack_i and match -> irq_o stays 1 and missed_o is unchanged. Same-cycle arm_i and disarm_i -> IDLE with cmp_o unchanged.
- Arm with cmp already below the timer (cmp=5, timer=1000) -> irq_o=1 one cycle after the first armed cycle. Periodic with period=0 -> one irq, then DONE.
- Assert arst_n_i mid-periodic with irq pending -> all outputs 0 immediately. Hold cke_i=0 across a match -> irq_o is not set until cke_i returns to 1.
